median_5_to_bram_writer: RTL and testbench

- Write-back end of the 5x5 median pre-processing path.
- Accepts median results as they emerge from the 5x5 median unit, one pixel per i_median_valid pulse.
- Writes each result into the output BRAM in raster order, generating write-enable and address.
- Signals row completion and frame completion to the downstream LBP stage.

---
 rtl/median_wb_pkg.sv | 27 ++
 rtl/median_wb_addr_gen.sv | 76 +++++++
 rtl/median_5_to_bram_writer.sv | 117 +++++++++++
 tb/tb_median_5_to_bram_writer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/median_wb_pkg.sv
// median_wb_pkg
//   Shared types and sizing helpers for the 5x5 median write-back block.
//   - state_e       : FSM state encoding (IDLE, WRITE, DONE)
//   - out_dim()     : output dimension of a KERNEL-wide valid-window filter
//   - border_off()  : half-kernel border thickness
//   - border_base() : first address of the centered output in a full frame
package median_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int out_dim(input int img, input int kernel);
        return img - kernel + 1;
    endfunction

    function automatic int border_off(input int kernel);
        return (kernel - 1) / 2;
    endfunction

    function automatic int border_base(input int img_w, input int kernel);
        return border_off(kernel) * img_w + border_off(kernel);
    endfunction

endpackage

// File: rtl/median_wb_addr_gen.sv
// median_wb_addr_gen
//   Column/row counters and BRAM address stepping for the median write-back.
//   Build option: MEDIAN_WB_BORDER_EN places the output centered in a full
//   IMG_WIDTH x IMG_HEIGHT frame (row wrap skips the border columns);
//   otherwise addresses are packed 0..OUT_W*OUT_H-1.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : restart counters for a new frame
//   i_adv          : one pixel accepted, step to the next location
//   o_addr         : address for the current pixel
//   o_last_col     : current pixel is the last of its row
//   o_last_pixel   : current pixel is the last of the frame
module median_wb_addr_gen
    import median_wb_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int KERNEL     = 5,
    parameter int ADDR_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_col,
    output logic              o_last_pixel
);

    localparam int OUT_W = out_dim(IMG_WIDTH, KERNEL);
    localparam int OUT_H = out_dim(IMG_HEIGHT, KERNEL);
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

`ifdef MEDIAN_WB_BORDER_EN
    // Row wrap jumps over the right border of this row and the left border
    // of the next one: 1 + (KERNEL-1) locations.
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(border_base(IMG_WIDTH, KERNEL));
    localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(KERNEL);
`else
    localparam logic [ADDR_W-1:0] BASE      = '0;
    localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(1);
`endif

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] addr;
    logic              last_row;

    assign o_last_col   = (col == CW'(OUT_W - 1));
    assign last_row     = (row == RW'(OUT_H - 1));
    assign o_last_pixel = o_last_col && last_row;
    assign o_addr       = addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (i_clr) begin
            col  <= '0;
            row  <= '0;
            addr <= BASE;
        end else if (i_adv) begin
            if (o_last_col) begin
                col  <= '0;
                row  <= last_row ? '0 : row + RW'(1);
                addr <= addr + WRAP_STEP;
            end else begin
                col  <= col + CW'(1);
                addr <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/median_5_to_bram_writer.sv
// median_5_to_bram_writer
//   Write-back end of the 5x5 median path: each accepted median result is
//   written to the output BRAM in raster order one cycle after it arrives.
//   Build option: MEDIAN_WB_BORDER_EN (centered placement in a full frame,
//   see median_wb_addr_gen).
// Ports:
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_start         : arm for a new frame (taken only in IDLE)
//   i_median_valid  : median result valid this cycle
//   i_median_data   : median result
//   o_bram_we/addr/wdata : registered BRAM write port
//   o_row_done      : pulses with the last write of each output row
//   o_frame_done    : pulses on entering DONE (same cycle as the final write)
//   o_busy          : high in WRITE
//   o_drop          : sticky, a valid arrived outside WRITE
//   o_state         : current FSM state
module median_5_to_bram_writer
    import median_wb_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int KERNEL     = 5,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_median_valid,
    input  logic [DATA_W-1:0] i_median_data,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_wdata,
    output logic              o_row_done,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic              o_drop,
    output logic [1:0]        o_state
);

    state_e            state, state_next;
    logic              start_take;
    logic              accept;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_col;
    logic              last_pixel;

    median_wb_addr_gen #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .KERNEL    (KERNEL),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (start_take),
        .i_adv       (accept),
        .o_addr      (cur_addr),
        .o_last_col  (last_col),
        .o_last_pixel(last_pixel)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_take = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    start_take = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (i_median_valid) begin
                    accept = 1'b1;
                    if (last_pixel) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write port, row/frame strobes and drop flag are all registered so they
    // line up with the one-cycle write latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bram_we    <= 1'b0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
            o_row_done   <= 1'b0;
            o_frame_done <= 1'b0;
            o_drop       <= 1'b0;
        end else begin
            o_bram_we    <= accept;
            o_row_done   <= accept && last_col;
            o_frame_done <= accept && last_pixel;
            if (accept) begin
                o_bram_addr  <= cur_addr;
                o_bram_wdata <= i_median_data;
            end
            // A valid in the same IDLE cycle as start is still a drop, so the
            // set term wins over the start clear.
            o_drop <= (o_drop && !start_take) || (i_median_valid && (state != WRITE));
        end
    end

    assign o_busy  = (state == WRITE);
    assign o_state = state;

endmodule

// File: tb/tb_median_5_to_bram_writer.sv
module tb_median_5_to_bram_writer;

    localparam int IW = 8, IH = 8, K = 5, DW = 8, AW = 12;
    localparam int OW = IW - K + 1, OH = IH - K + 1, NPIX = OW * OH;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          we, row_done, frame_done, busy, drop;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    st;

    int n_tests = 0, n_fail = 0;

    // reference model: 0 idle, 1 writing, 2 done
    int   m_phase = 0, m_k = 0, m_fdone = 0;
    logic m_drop = 1'b0;

    median_5_to_bram_writer #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .KERNEL(K), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_median_valid(valid), .i_median_data(data),
        .o_bram_we(we), .o_bram_addr(addr), .o_bram_wdata(wdata),
        .o_row_done(row_done), .o_frame_done(frame_done), .o_busy(busy),
        .o_drop(drop), .o_state(st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int k);
`ifdef MEDIAN_WB_BORDER_EN
        return ((K - 1) / 2) * IW + (K - 1) / 2 + (k / OW) * IW + (k % OW);
`else
        return k;
`endif
    endfunction

    // One clock: apply inputs, predict from the model, check after the edge.
    task automatic step(input logic s, input logic v, input logic [DW-1:0] d);
        logic e_we, e_rd, e_fd;
        int   e_addr;
        e_we = 0; e_rd = 0; e_fd = 0; e_addr = 0;
        start = s; valid = v; data = d;
        case (m_phase)
            0: begin
                if (s) begin m_phase = 1; m_k = 0; m_drop = 0; end
                if (v) m_drop = 1;
            end
            1: begin
                if (v) begin
                    e_we   = 1;
                    e_addr = exp_addr(m_k);
                    e_rd   = (m_k % OW) == OW - 1;
                    if (m_k == NPIX - 1) begin e_fd = 1; m_phase = 2; end
                    m_k++;
                end
            end
            default: begin
                if (v) m_drop = 1;
                m_phase = 0;
            end
        endcase
        @(posedge clk); #1;
        chk("we", we, e_we);
        if (e_we) begin
            chk("addr", addr, e_addr);
            chk("wdata", wdata, d);
        end
        chk("row_done", row_done, e_rd);
        chk("frame_done", frame_done, e_fd);
        if (e_fd) m_fdone++;
        chk("busy", busy, m_phase == 1);
        chk("state", st, m_phase);
        chk("drop", drop, m_drop);
        start = 0; valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; valid = 0;
        #2;
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_rd", row_done, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);
        chk("rst_state", st, 0);
        m_phase = 0; m_k = 0; m_drop = 0;
        #4 rst_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        int fd0;
        #1;
        do_reset();

        // back-to-back frame, data 0..15, then two idle cycles
        step(1, 0, 0);
        for (int i = 0; i < NPIX; i++) step(0, 1, DW'(i));
        step(0, 0, 0);
        step(0, 0, 0);
        chk("frames_done", m_fdone, 1);

        // valid every 3rd cycle across row boundaries
        step(1, 0, 0);
        for (int i = 0; i < NPIX; i++) begin
            step(0, 1, DW'($urandom_range(0, 255)));
            step(0, 0, 0);
            step(0, 0, 0);
        end
        step(0, 0, 0);

        // valid in IDLE -> drop, sticky until start; start+valid together
        step(0, 1, 8'h55);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < NPIX; i++) step(0, 1, DW'($urandom_range(0, 255)));
        step(0, 1, 8'h11);        // valid while DONE
        step(1, 1, 8'h22);        // start with simultaneous valid
        for (int i = 0; i < NPIX; i++) step(0, 1, DW'($urandom_range(0, 255)));
        step(0, 0, 0);

        // reset after 6 writes, then a clean frame
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, DW'($urandom_range(0, 255)));
        do_reset();
        fd0 = m_fdone;
        step(1, 0, 0);
        for (int i = 0; i < NPIX; i++) step(0, 1, DW'(8'hA0 + i));
        step(0, 0, 0);
        chk("fd_after_rst", m_fdone - fd0, 1);

        // start pulses mid-frame are ignored
        step(1, 0, 0);
        for (int i = 0; i < NPIX; i++) step((i % 5) == 2, 1, DW'($urandom_range(0, 255)));
        step(0, 0, 0);
        step(0, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, DW'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
